hamming_scrub_ctrl: RTL and testbench

HAMMING_SCRUB_CTRL -- requirements
Module: hamming_scrub_ctrl

---
 rtl/hamming_scrub_ctrl_pkg.sv | 34 +++
 rtl/hamming_decoder.sv | 22 ++
 rtl/hamming_encoder.sv | 17 +
 rtl/hamming_scrub_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_hamming_scrub_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_scrub_ctrl_pkg.sv
// Shared types and constants for the Hamming-protected scrub controller.
// The syndrome-to-position table covers codeword positions 1..7 (bit index = position-1).
package hamming_scrub_ctrl_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOST_RD  = 3'd1,
        ST_HOST_RSP = 3'd2,
        ST_SCRUB_RD = 3'd3,
        ST_SCRUB_WB = 3'd4
    } state_e;

    // A nonzero syndrome names the 1-based codeword position to flip.
    function automatic logic [CW_W-1:0] syn_to_mask(input logic [SYN_W-1:0] syn);
        logic [CW_W-1:0] mask;
        mask = '0;
        case (syn)
            3'd1: mask = 7'b000_0001;
            3'd2: mask = 7'b000_0010;
            3'd3: mask = 7'b000_0100;
            3'd4: mask = 7'b000_1000;
            3'd5: mask = 7'b001_0000;
            3'd6: mask = 7'b010_0000;
            3'd7: mask = 7'b100_0000;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/hamming_decoder.sv
// (7,4) Hamming decoder: corrects the bit named by the syndrome, flags any nonzero syndrome.
module hamming_decoder
    import hamming_scrub_ctrl_pkg::*;
(
    input  logic [CW_W-1:0]   cw,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    logic [SYN_W-1:0] syn;
    logic [CW_W-1:0]  fixed;

    always_comb begin
        syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        fixed  = cw ^ syn_to_mask(syn);
        data   = {fixed[6], fixed[5], fixed[4], fixed[2]};
        err    = |syn;
    end

endmodule

// File: rtl/hamming_encoder.sv
// (7,4) even-parity Hamming encoder: codeword = {d3,d2,d1,p4,d0,p2,p1}.
module hamming_encoder (
    input  logic [3:0] data,
    output logic [6:0] codeword
);

    always_comb begin
        codeword[0] = data[0] ^ data[1] ^ data[3];
        codeword[1] = data[0] ^ data[2] ^ data[3];
        codeword[2] = data[0];
        codeword[3] = data[1] ^ data[2] ^ data[3];
        codeword[4] = data[1];
        codeword[5] = data[2];
        codeword[6] = data[3];
    end

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Hamming-protected codeword store with host port, raw debug write port and background scrubber.
// Define SCRUB_EN to build the scrubber; otherwise scrub_busy is tied low.
module hamming_scrub_ctrl
    import hamming_scrub_ctrl_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int SCRUB_INTERVAL = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [$clog2(DEPTH)-1:0] req_addr,
    input  logic [3:0]               req_wdata,
    output logic                     rsp_valid,
    output logic [3:0]               rsp_rdata,
    output logic                     rsp_err_corr,
    input  logic                     dbg_we,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    input  logic [6:0]               dbg_cw,
    output logic                     scrub_busy,
    output logic [7:0]               corr_count
);

    localparam int AW = $clog2(DEPTH);

    state_e              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [7:0]          corr_q, corr_d;
    logic [CW_W-1:0]     mem_q [DEPTH];

    logic                host_wr;
    logic                inc_corr;
    logic [CW_W-1:0]     host_cw;
    logic [CW_W-1:0]     dec_cw;
    logic [DATA_W-1:0]   dec_data;
    logic                dec_err;

    hamming_encoder u_enc_host (
        .data     (req_wdata),
        .codeword (host_cw)
    );

    hamming_decoder u_dec (
        .cw   (dec_cw),
        .data (dec_data),
        .err  (dec_err)
    );

`ifdef SCRUB_EN
    localparam int CNT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

    logic [AW-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [CW_W-1:0]   wb_cw;
    logic              scrub_wr;

    hamming_encoder u_enc_wb (
        .data     (wb_data_q),
        .codeword (wb_cw)
    );

    assign dec_cw     = (state_q == ST_SCRUB_RD) ? mem_q[ptr_q] : mem_q[addr_q];
    assign scrub_busy = (state_q == ST_SCRUB_RD) || (state_q == ST_SCRUB_WB);

    // Interval counter runs only while idle; a new expiry re-arms pending even as it is served.
    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (state_q == ST_IDLE && !req_valid && pending_q) begin
            pending_d = 1'b0;
        end
        if (state_q == ST_IDLE) begin
            if (cnt_q == CNT_W'(SCRUB_INTERVAL - 1)) begin
                cnt_d     = '0;
                pending_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end
`else
    logic unused_interval;

    assign unused_interval = (SCRUB_INTERVAL > 0);
    assign dec_cw          = mem_q[addr_q];
    assign scrub_busy      = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        corr_d      = corr_q;
        host_wr     = 1'b0;
        inc_corr    = 1'b0;
`ifdef SCRUB_EN
        ptr_d       = ptr_q;
        wb_data_d   = wb_data_q;
        scrub_wr    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_we) begin
                        host_wr = 1'b1;
                    end else begin
                        addr_d  = req_addr;
                        state_d = ST_HOST_RD;
                    end
                end
`ifdef SCRUB_EN
                else if (pending_q) begin
                    state_d = ST_SCRUB_RD;
                end
`endif
            end
            ST_HOST_RD: state_d = ST_HOST_RSP;
            ST_HOST_RSP: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = dec_data;
                rsp_err_d   = dec_err;
                inc_corr    = dec_err;
                state_d     = ST_IDLE;
            end
`ifdef SCRUB_EN
            ST_SCRUB_RD: begin
                wb_data_d = dec_data;
                if (dec_err) begin
                    state_d = ST_SCRUB_WB;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_SCRUB_WB: begin
                scrub_wr = 1'b1;
                inc_corr = 1'b1;
                ptr_d    = ptr_q + 1'b1;
                state_d  = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (inc_corr && corr_q != 8'hFF) begin
            corr_d = corr_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            corr_q      <= '0;
`ifdef SCRUB_EN
            ptr_q       <= '0;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            corr_q      <= corr_d;
`ifdef SCRUB_EN
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
`endif
        end
        addr_q <= addr_d;
`ifdef SCRUB_EN
        wb_data_q <= wb_data_d;
`endif
    end

    // Storage is never reset; the raw debug write is last so it wins any same-address collision.
    always_ff @(posedge clk) begin
        if (!rst && host_wr) begin
            mem_q[req_addr] <= host_cw;
        end
`ifdef SCRUB_EN
        if (!rst && scrub_wr) begin
            mem_q[ptr_q] <= wb_cw;
        end
`endif
        if (dbg_we) begin
            mem_q[dbg_addr] <= dbg_cw;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err_corr = rsp_err_q;
    assign corr_count   = corr_q;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Randomised self-checking bench for hamming_scrub_ctrl with a position-based Hamming reference model.
module tb_hamming_scrub_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef SCRUB_EN
    localparam int SI    = 8;
    localparam bit SCRUB = 1'b1;
`else
    localparam int SI    = 64;
    localparam bit SCRUB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [3:0]    req_wdata = '0;
    logic          rsp_valid;
    logic [3:0]    rsp_rdata;
    logic          rsp_err_corr;
    logic          dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [6:0]    dbg_cw = '0;
    logic          scrub_busy;
    logic [7:0]    corr_count;

    always #5 clk = ~clk;

    hamming_scrub_ctrl #(.DEPTH(DEPTH), .SCRUB_INTERVAL(SI)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err_corr(rsp_err_corr),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_cw(dbg_cw),
        .scrub_busy(scrub_busy), .corr_count(corr_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Data bits occupy the non-power-of-two positions; parity p covers every position with bit p set.
    function automatic logic [6:0] m_enc(input logic [3:0] d);
        logic [6:0] cw;
        int k;
        cw = '0;
        k = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= 4; p = p * 2) begin
            for (int pos = 1; pos <= 7; pos++) begin
                if (pos != p && (pos & p) != 0) cw[p-1] = cw[p-1] ^ cw[pos-1];
            end
        end
        return cw;
    endfunction

    function automatic void m_dec(input logic [6:0] cw, output logic [3:0] d, output logic err);
        int s;
        int k;
        s = 0;
        k = 0;
        for (int pos = 1; pos <= 7; pos++) if (cw[pos-1]) s = s ^ pos;
        if (s != 0) cw[s-1] = ~cw[s-1];
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[k] = cw[pos-1];
                k++;
            end
        end
        err = (s != 0);
    endfunction

    // Reference model: kind 0 = idle, 1 = host read, 2 = scrub; step counts cycles inside the operation.
    logic [6:0]    m_mem [DEPTH];
    int            m_kind = 0;
    int            m_step = 0;
    logic [AW-1:0] m_raddr = '0;
    logic [AW-1:0] m_ptr = '0;
    logic [3:0]    m_wb = '0;
    int            m_cnt = 0;
    bit            m_pend = 1'b0;
    bit            m_rst_seen = 1'b0;
    bit            e_valid = 1'b0;
    logic [3:0]    e_rdata = '0;
    bit            e_err = 1'b0;
    int            e_cc = 0;
    bit            chk_en = 1'b0;

    always @(posedge clk) begin : model
        logic [3:0]    d;
        logic          e;
        bit            idle, served, hit, hw, sw;
        logic [AW-1:0] sa;
        hw = 1'b0; sw = 1'b0; served = 1'b0; hit = 1'b0; sa = '0;
        if (rst) begin
            m_kind = 0; m_step = 0; m_cnt = 0; m_pend = 1'b0; m_ptr = '0;
            e_valid = 1'b0; e_rdata = '0; e_err = 1'b0; e_cc = 0; m_rst_seen = 1'b1;
        end else begin
            m_rst_seen = 1'b0;
            e_valid = 1'b0;
            idle = (m_kind == 0);
            if (m_kind == 1) begin
                if (m_step == 0) begin
                    m_step = 1;
                end else begin
                    m_dec(m_mem[m_raddr], d, e);
                    e_valid = 1'b1; e_rdata = d; e_err = e;
                    if (e && e_cc < 255) e_cc++;
                    m_kind = 0;
                end
            end else if (m_kind == 2) begin
                if (m_step == 0) begin
                    m_dec(m_mem[m_ptr], d, e);
                    if (e) begin
                        m_wb = d; m_step = 1;
                    end else begin
                        m_ptr = m_ptr + 1'b1; m_kind = 0;
                    end
                end else begin
                    sw = 1'b1; sa = m_ptr;
                    if (e_cc < 255) e_cc++;
                    m_ptr = m_ptr + 1'b1; m_kind = 0;
                end
            end else if (req_valid) begin
                if (req_we) hw = 1'b1;
                else begin
                    m_kind = 1; m_step = 0; m_raddr = req_addr;
                end
            end else if (SCRUB && m_pend) begin
                m_kind = 2; m_step = 0; served = 1'b1;
            end
            if (SCRUB && idle) begin
                if (m_cnt == SI - 1) begin
                    m_cnt = 0; hit = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
            m_pend = (m_pend && !served) || hit;
            if (hw) m_mem[req_addr] = m_enc(req_wdata);
            if (sw) m_mem[sa] = m_enc(m_wb);
        end
        if (dbg_we) m_mem[dbg_addr] = dbg_cw;
        chk_en = 1'b1;
    end

    int busy_seen = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", {31'd0, req_ready}, {31'd0, m_kind == 0});
            check("scrub_busy", {31'd0, scrub_busy}, {31'd0, m_kind == 2});
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_valid});
            check("corr_count", {24'd0, corr_count}, e_cc);
            if (e_valid || m_rst_seen) begin
                check("rsp_rdata", {28'd0, rsp_rdata}, {28'd0, e_rdata});
                check("rsp_err_corr", {31'd0, rsp_err_corr}, {31'd0, e_err});
            end
            if (scrub_busy === 1'b1) busy_seen = 1;
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [3:0] d);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    // Optionally injects a raw codeword on the same edge the read is accepted.
    task automatic host_read(input logic [AW-1:0] a, input bit inj, input logic [6:0] inj_cw,
                             output logic [3:0] d, output logic e, output logic [7:0] cc);
        int t;
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        if (inj) begin
            dbg_we = 1'b1; dbg_addr = a; dbg_cw = inj_cw;
        end
        @(negedge clk);
        req_valid = 1'b0; dbg_we = 1'b0;
        t = 0;
        while (rsp_valid !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("rd_latency", t, 32'd2);
        d = rsp_rdata; e = rsp_err_corr; cc = corr_count;
    endtask

    logic [3:0] rd;
    logic       re;
    logic [7:0] rc;
    logic [7:0] cc_before;

    initial begin
        // Reset with every entry loaded through the raw port so nothing is ever read uninitialised.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            dbg_we = 1'b1; dbg_addr = AW'(i); dbg_cw = m_enc(4'($urandom));
        end
        @(negedge clk);
        dbg_we = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", {31'd0, req_ready}, 32'd1);
        check("post_reset_cc", {24'd0, corr_count}, 32'd0);
        check("post_reset_rsp", {31'd0, rsp_valid}, 32'd0);

        check("model_enc_0110", {25'd0, m_enc(4'b0110)}, 32'h33);
        check("model_enc_1011", {25'd0, m_enc(4'b1011)}, 32'h55);
        m_dec(7'h51, rd, re);
        check("model_dec_data", {28'd0, rd}, 32'hB);
        check("model_dec_err", {31'd0, re}, 32'd1);

        host_write(4'd3, 4'b0110);
        host_read(4'd3, 1'b0, 7'd0, rd, re, rc);
        check("w3r3_data", {28'd0, rd}, 32'b0110);
        check("w3r3_err", {31'd0, re}, 32'd0);
        check("w3r3_cc", {24'd0, rc}, 32'd0);

        host_read(4'd5, 1'b1, m_enc(4'b1011) ^ 7'b000_0100, rd, re, rc);
        check("a5_rd1_data", {28'd0, rd}, 32'b1011);
        check("a5_rd1_err", {31'd0, re}, 32'd1);
        check("a5_rd1_cc", {24'd0, rc}, 32'd1);
        host_read(4'd5, 1'b0, 7'd0, rd, re, rc);
        check("a5_rd2_err", {31'd0, re}, 32'd1);
        check("a5_rd2_cc", {24'd0, rc}, 32'd2);

        // Reset while the read sits in HOST_RD.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5;
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_rsp", {31'd0, rsp_valid}, 32'd0);
        check("abort_cc", {24'd0, corr_count}, 32'd0);
        check("abort_busy", {31'd0, scrub_busy}, 32'd0);

        for (int c = 0; c < 800; c++) begin
            req_valid = ($urandom % 3) == 0;
            req_we    = $urandom % 2;
            req_addr  = AW'($urandom);
            req_wdata = 4'($urandom);
            dbg_we    = ($urandom % 12) == 0;
            dbg_addr  = AW'($urandom);
            case ($urandom % 3)
                0: dbg_cw = m_enc(4'($urandom));
                1: dbg_cw = m_enc(4'($urandom)) ^ (7'd1 << ($urandom % 7));
                default: dbg_cw = 7'($urandom);
            endcase
            rst = ($urandom % 150) == 0;
            @(negedge clk);
        end
        req_valid = 1'b0; dbg_we = 1'b0; rst = 1'b0;
        @(negedge clk);

        // Back-to-back reads of a corrupted entry leave no idle gap, so only the host path counts.
        host_read(4'd9, 1'b1, m_enc(4'b0101) ^ 7'b100_0000, rd, re, rc);
        for (int i = 0; i < 265; i++) host_read(4'd9, 1'b0, 7'd0, rd, re, rc);
        check("sat_data", {28'd0, rd}, 32'b0101);
        check("sat_cc", {24'd0, corr_count}, 32'd255);

        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            dbg_we = 1'b1; dbg_addr = AW'(i); dbg_cw = m_enc(4'($urandom));
            @(negedge clk);
        end
        dbg_we = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);
        cc_before = corr_count;
        busy_seen = 0;
        dbg_we = 1'b1; dbg_addr = '0; dbg_cw = m_enc(4'b1100) ^ (7'd1 << ($urandom % 7));
        @(negedge clk);
        dbg_we = 1'b0;
        repeat (1000) @(negedge clk);
        check("idle_busy_seen", busy_seen, {31'd0, SCRUB});
        check("idle_cc", {24'd0, corr_count}, {24'd0, cc_before} + {31'd0, SCRUB});
        host_read(4'd0, 1'b0, 7'd0, rd, re, rc);
        check("idle_rd0_data", {28'd0, rd}, 32'b1100);
        check("idle_rd0_err", {31'd0, re}, {31'd0, !SCRUB});

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
